// File: rtl/ahblite_bus_mux.sv
// AHB-Lite address decoder and response multiplexer for one master and NS slaves,
// with a built-in default slave (two-cycle ERROR on unmapped pages) and a stall watchdog.
module ahblite_bus_mux #(
   parameter int                  NS        = 5,
   parameter int                  PW        = 8,
   parameter logic [NS*PW-1:0]    PAGES     = {8'h40, 8'h77, 8'h48, 8'h20, 8'h00},
   parameter int                  TO_CYC    = 255,
   parameter logic [31:0]         DEF_RDATA = 32'hDEADBEEF,
   localparam int                 IW        = (NS > 1) ? $clog2(NS) : 1
) (
   input  logic                   HCLK,
   input  logic                   HRESETn,
   input  logic [31:0]            HADDR,
   input  logic [1:0]             HTRANS,
   output logic                   HREADY,
   output logic                   HRESP,
   output logic [31:0]            HRDATA,
   output logic [NS-1:0]          HSEL,
   input  logic [NS-1:0]          HREADYOUT_S,
   input  logic [NS-1:0]          HRESP_S,
   input  logic [NS*32-1:0]       HRDATA_S,
   output logic                   TIMEOUT,
   output logic [IW-1:0]          TO_IDX
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ERR1,
      ST_ERR2,
      ST_TO1,
      ST_TO2
   } state_t;

   localparam logic [15:0] TO_LAST = 16'(TO_CYC - 1);
   localparam bit          TO_EN   = (TO_CYC != 0);

   state_t          state, state_nxt;
   logic [NS-1:0]   asel;
   logic [15:0]     wd_cnt;
   logic [PW-1:0]   page;
   logic            nomatch;
   logic            active;
   logic            own;
   logic            stall;
   logic            expire;
   logic            sel_rdy;
   logic            sel_resp;
   logic [31:0]     sel_rdata;
   logic            unused_bits;

   function automatic logic [IW-1:0] onehot_idx(input logic [NS-1:0] oh);
      logic [IW-1:0] idx;
      idx = '0;
      for (int i = 0; i < NS; i++) begin
         if (oh[i]) idx = IW'(i);
      end
      return idx;
   endfunction

   assign page        = HADDR[31 -: PW];
   assign active      = HTRANS[1];
   assign unused_bits = ^{HADDR[31-PW:0], HTRANS[0]};

   // Address decode: first matching slot wins so duplicate pages keep HSEL one-hot.
   always_comb begin
      HSEL    = '0;
      nomatch = 1'b1;
      for (int i = 0; i < NS; i++) begin
         if (nomatch && (page == PAGES[i*PW +: PW])) begin
            HSEL[i] = 1'b1;
            nomatch = 1'b0;
         end
      end
   end

   always_comb begin
      sel_rdy   = 1'b1;
      sel_resp  = 1'b0;
      sel_rdata = '0;
      for (int i = 0; i < NS; i++) begin
         if (asel[i]) begin
            sel_rdy   = HREADYOUT_S[i];
            sel_resp  = HRESP_S[i];
            sel_rdata = HRDATA_S[i*32 +: 32];
         end
      end
   end

   assign own    = (state == ST_IDLE) && (|asel);
   assign stall  = own && !sel_rdy;
   assign expire = TO_EN && stall && (wd_cnt == TO_LAST);

   // Response mux: the data-phase slave only owns the bus while the FSM is idle.
   always_comb begin
      HREADY = 1'b1;
      HRESP  = 1'b0;
      HRDATA = DEF_RDATA;
      case (state)
         ST_IDLE: begin
            if (own) begin
               HREADY = sel_rdy;
               HRESP  = sel_resp;
               HRDATA = sel_rdata;
            end
         end
         ST_ERR1, ST_TO1: begin
            HREADY = 1'b0;
            HRESP  = 1'b1;
         end
         ST_ERR2, ST_TO2: begin
            HREADY = 1'b1;
            HRESP  = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (expire)
               state_nxt = ST_TO1;
            else if (HREADY && active && nomatch)
               state_nxt = ST_ERR1;
         end
         ST_ERR1: state_nxt = ST_ERR2;
         ST_TO1:  state_nxt = ST_TO2;
         ST_ERR2, ST_TO2: begin
            state_nxt = (active && nomatch) ? ST_ERR1 : ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state   <= ST_IDLE;
         asel    <= '0;
         wd_cnt  <= '0;
         TIMEOUT <= 1'b0;
         TO_IDX  <= '0;
      end else begin
         state   <= state_nxt;
         TIMEOUT <= expire;
         if (expire) begin
            asel   <= '0;
            TO_IDX <= onehot_idx(asel);
         end else if (HREADY) begin
            asel   <= HSEL & {NS{active}};
         end
         if (HREADY || expire)
            wd_cnt <= '0;
         else if (stall)
            wd_cnt <= wd_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_ahblite_bus_mux.sv
// Scoreboard bench for ahblite_bus_mux: a transaction-level model predicts each data
// phase outcome, and a negedge monitor compares what the bus presents.
module tb_ahblite_bus_mux;

   localparam int          NS    = 5;
   localparam int          IW    = 3;
   localparam int          TO    = 4;
   localparam logic [39:0] PAGES = {8'h40, 8'h77, 8'h48, 8'h20, 8'h00};
   localparam logic [31:0] DEF   = 32'hDEADBEEF;
   localparam logic [1:0]  NSQ   = 2'b10;

   typedef struct {
      logic [31:0] addr;
      logic [1:0]  htrans;
      int          w;
      bit          serr;
   } txn_t;

   typedef struct {
      int          waits;
      bit          prev_resp;
      bit          resp;
      logic [31:0] rdata;
      int          nto;
      int          idx;
   } exp_t;

   logic              HCLK = 1'b0;
   logic              HRESETn;
   logic [31:0]       HADDR;
   logic [1:0]        HTRANS;
   logic              HREADY, HRESP;
   logic [31:0]       HRDATA;
   logic [NS-1:0]     HSEL;
   logic [NS-1:0]     HREADYOUT_S, HRESP_S;
   logic [NS*32-1:0]  HRDATA_S;
   logic              TIMEOUT;
   logic [IW-1:0]     TO_IDX;

   logic [31:0]       z_haddr;
   logic [1:0]        z_htrans;
   logic              z_hready, z_hresp;
   logic [31:0]       z_hrdata;
   logic [NS-1:0]     z_hsel;
   logic [NS-1:0]     z_rdyout;
   logic              z_timeout;
   logic [IW-1:0]     z_to_idx;

   int   total = 0;
   int   bad   = 0;
   exp_t exp_q[$];
   bit   mon_en = 1'b0;
   bit   in_dp;
   int   m_waits, m_nto;
   bit   m_prev;
   txn_t dp;
   bit   dp_valid = 1'b0;
   int   k = 0;
   logic [7:0] page_tab [NS] = '{8'h00, 8'h20, 8'h48, 8'h77, 8'h40};
   logic [7:0] unm_tab  [4]  = '{8'h10, 8'hFF, 8'h01, 8'h21};

   ahblite_bus_mux #(.NS(NS), .PW(8), .PAGES(PAGES), .TO_CYC(TO), .DEF_RDATA(DEF)) u_dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS),
      .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA), .HSEL(HSEL),
      .HREADYOUT_S(HREADYOUT_S), .HRESP_S(HRESP_S), .HRDATA_S(HRDATA_S),
      .TIMEOUT(TIMEOUT), .TO_IDX(TO_IDX)
   );

   ahblite_bus_mux #(.NS(NS), .PW(8), .PAGES(PAGES), .TO_CYC(0), .DEF_RDATA(DEF)) u_dut_nowd (
      .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(z_haddr), .HTRANS(z_htrans),
      .HREADY(z_hready), .HRESP(z_hresp), .HRDATA(z_hrdata), .HSEL(z_hsel),
      .HREADYOUT_S(z_rdyout), .HRESP_S(HRESP_S), .HRDATA_S(HRDATA_S),
      .TIMEOUT(z_timeout), .TO_IDX(z_to_idx)
   );

   always #5 HCLK = ~HCLK;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, want);
      end
   endtask

   function automatic int lookup(input logic [31:0] a);
      for (int i = 0; i < NS; i++)
         if (a[31:24] == page_tab[i]) return i;
      return -1;
   endfunction

   function automatic logic [NS-1:0] exp_hsel(input logic [31:0] a);
      logic [NS-1:0] h;
      int s;
      h = '0;
      s = lookup(a);
      if (s >= 0) h[s] = 1'b1;
      return h;
   endfunction

   // Outcome of one transfer from the bus rules: stall cycles seen by the master,
   // last two responses, final read data and whether the watchdog fires.
   function automatic exp_t model(input txn_t t);
      exp_t e;
      int   s, stall;
      s = lookup(t.addr);
      e.waits = 0; e.prev_resp = 1'b0; e.resp = 1'b0; e.rdata = DEF; e.nto = 0; e.idx = -1;
      if (t.htrans[1]) begin
         if (s < 0) begin
            e.waits = 1; e.prev_resp = 1'b1; e.resp = 1'b1;
         end else begin
            stall = t.w + int'(t.serr);
            if (stall >= TO) begin
               e.waits = TO + 1; e.prev_resp = 1'b1; e.resp = 1'b1; e.nto = 1; e.idx = s;
            end else begin
               e.waits = stall; e.prev_resp = t.serr; e.resp = t.serr;
               e.rdata = 32'hA000_0000 + 32'(s);
            end
         end
      end
      return e;
   endfunction

   function automatic txn_t mk(input logic [31:0] a, input logic [1:0] tr, input int w, input bit serr);
      txn_t t;
      t.addr = a; t.htrans = tr; t.w = w; t.serr = serr;
      return t;
   endfunction

   task automatic drive_slaves();
      int s;
      HREADYOUT_S = '1;
      HRESP_S     = '0;
      s = lookup(dp.addr);
      if (dp_valid && dp.htrans[1] && s >= 0) begin
         if (!dp.serr) begin
            HREADYOUT_S[s] = (k >= dp.w);
         end else if (k < dp.w) begin
            HREADYOUT_S[s] = 1'b0;
         end else if (k == dp.w) begin
            HREADYOUT_S[s] = 1'b0;
            HRESP_S[s]     = 1'b1;
         end else begin
            HRESP_S[s]     = 1'b1;
         end
      end
   endtask

   task automatic issue(input txn_t t);
      bit hr;
      int guard;
      HADDR  = t.addr;
      HTRANS = t.htrans;
      exp_q.push_back(model(t));
      guard = 0;
      do begin
         drive_slaves();
         @(negedge HCLK);
         if (guard == 0) check("hsel", {27'd0, HSEL}, {27'd0, exp_hsel(t.addr)});
         hr = HREADY;
         @(posedge HCLK); #1;
         if (!hr) k++;
         guard++;
         if (guard > 100) begin
            bad++; total++;
            $display("FAIL bus_hang: got %0d stall cycles expected at most 100", guard);
            $display("test done: total=%0d bad=%0d", total, bad);
            $fatal(1, "bus hang");
         end
      end while (!hr);
      dp = t; dp_valid = 1'b1; k = 0;
   endtask

   always @(negedge HCLK) begin
      exp_t e;
      if (!mon_en) begin
         in_dp = 1'b0; m_waits = 0; m_nto = 0; m_prev = 1'b0;
      end else begin
         if (in_dp) begin
            m_nto += int'(TIMEOUT);
            if (!HREADY) begin
               m_waits++;
               m_prev = HRESP;
            end else if (exp_q.size() == 0) begin
               total++; bad++;
               $display("FAIL scoreboard: got a completion expected none pending");
            end else begin
               e = exp_q.pop_front();
               check("waits", 32'(m_waits), 32'(e.waits));
               check("hresp", {31'd0, HRESP}, {31'd0, e.resp});
               check("hrdata", HRDATA, e.rdata);
               if (e.waits > 0) check("hresp_prev", {31'd0, m_prev}, {31'd0, e.prev_resp});
               check("timeout_cycles", 32'(m_nto), 32'(e.nto));
               if (e.idx >= 0) check("to_idx", {29'd0, TO_IDX}, 32'(e.idx));
               m_waits = 0; m_nto = 0; m_prev = 1'b0;
            end
         end else begin
            check("timeout_nodp", {31'd0, TIMEOUT}, 32'd0);
         end
         if (HREADY) in_dp = 1'b1;
      end
   end

   initial begin
      int nbad;
      for (int i = 0; i < NS; i++) HRDATA_S[i*32 +: 32] = 32'hA000_0000 + 32'(i);
      HREADYOUT_S = '1; HRESP_S = '0;
      HADDR = 32'h2000_0000; HTRANS = 2'b00;
      z_haddr = 32'h0; z_htrans = 2'b00; z_rdyout = '1;
      HRESETn = 1'b0;
      repeat (3) @(posedge HCLK);
      #1;
      check("rst_hsel", {27'd0, HSEL}, 32'b00010);
      check("rst_hready", {31'd0, HREADY}, 32'd1);
      check("rst_hresp", {31'd0, HRESP}, 32'd0);
      check("rst_hrdata", HRDATA, DEF);
      check("rst_timeout", {31'd0, TIMEOUT}, 32'd0);
      check("rst_to_idx", {29'd0, TO_IDX}, 32'd0);
      @(negedge HCLK) HRESETn = 1'b1;
      @(posedge HCLK); #1;
      mon_en = 1'b1;

      for (int s = 0; s < NS; s++) issue(mk({page_tab[s], 24'h0}, NSQ, 0, 1'b0));
      issue(mk(32'h1000_0000, NSQ, 0, 1'b0));
      issue(mk(32'h0000_0004, NSQ, 0, 1'b0));
      issue(mk(32'h1000_0000, NSQ, 0, 1'b0));
      issue(mk(32'hFF00_0000, NSQ, 0, 1'b0));
      issue(mk(32'h0000_0008, NSQ, 0, 1'b0));
      issue(mk(32'h4800_0000, NSQ, 0, 1'b1));
      issue(mk(32'h1000_0000, 2'b00, 0, 1'b0));
      issue(mk(32'h7700_0000, NSQ, 20, 1'b0));
      issue(mk(32'h7700_0010, NSQ, TO - 1, 1'b0));
      issue(mk(32'h0000_0000, NSQ, 0, 1'b0));

      for (int n = 0; n < 300; n++) begin
         int r;
         logic [31:0] a;
         a = $urandom;
         r = $urandom_range(0, 7);
         if (r < NS) begin
            a[31:24] = page_tab[r];
            issue(mk(a, NSQ, $urandom_range(0, 5), ($urandom_range(0, 3) == 0)));
         end else if (r == 5) begin
            a[31:24] = unm_tab[$urandom_range(0, 3)];
            issue(mk(a, 2'b11, 0, 1'b0));
         end else begin
            issue(mk(a, (r == 6) ? 2'b00 : 2'b01, 0, 1'b0));
         end
      end
      issue(mk(32'h0, 2'b00, 0, 1'b0));
      check("drain1", 32'(exp_q.size()), 32'd1);
      mon_en = 1'b0; exp_q.delete(); dp_valid = 1'b0; drive_slaves();

      // Asynchronous reset while in the first error cycle.
      @(posedge HCLK); #1;
      HADDR = 32'h1000_0000; HTRANS = NSQ;
      @(posedge HCLK); #1;
      HTRANS = 2'b00;
      #1;
      check("err1_hready", {31'd0, HREADY}, 32'd0);
      check("err1_hresp", {31'd0, HRESP}, 32'd1);
      HRESETn = 1'b0; #1;
      check("arst_err_hready", {31'd0, HREADY}, 32'd1);
      check("arst_err_hresp", {31'd0, HRESP}, 32'd0);
      @(negedge HCLK) HRESETn = 1'b1;

      // Asynchronous reset with the watchdog at a count of 2.
      @(posedge HCLK); #1;
      HADDR = 32'h7700_0000; HTRANS = NSQ;
      @(posedge HCLK); #1;
      HTRANS = 2'b00; HREADYOUT_S[3] = 1'b0;
      repeat (2) @(posedge HCLK);
      #1;
      check("wd_stall_hready", {31'd0, HREADY}, 32'd0);
      HRESETn = 1'b0; #1;
      check("arst_wd_hready", {31'd0, HREADY}, 32'd1);
      check("arst_wd_hresp", {31'd0, HRESP}, 32'd0);
      check("arst_wd_hrdata", HRDATA, DEF);
      @(negedge HCLK) HRESETn = 1'b1;
      HREADYOUT_S = '1;
      @(posedge HCLK); #1;
      k = 0; dp_valid = 1'b0;
      mon_en = 1'b1;
      issue(mk(32'h1000_0000, NSQ, 0, 1'b0));
      issue(mk(32'h7700_0000, NSQ, TO - 1, 1'b0));
      issue(mk(32'h2000_0000, NSQ, 1, 1'b0));
      issue(mk(32'h0, 2'b00, 0, 1'b0));
      check("drain2", 32'(exp_q.size()), 32'd1);
      mon_en = 1'b0; exp_q.delete(); dp_valid = 1'b0; drive_slaves();

      // Watchdog disabled: a 1000-cycle stall is never aborted.
      z_haddr = 32'h7700_0000; z_htrans = NSQ;
      @(posedge HCLK); #1;
      z_htrans = 2'b00; z_rdyout[3] = 1'b0;
      nbad = 0;
      repeat (1000) begin
         @(negedge HCLK);
         if (z_hready || z_timeout) nbad++;
      end
      check("nowd_stall", 32'(nbad), 32'd0);
      @(posedge HCLK); #1;
      z_rdyout = '1;
      @(negedge HCLK);
      check("nowd_done_hready", {31'd0, z_hready}, 32'd1);
      check("nowd_done_hrdata", z_hrdata, 32'hA000_0003);
      check("nowd_done_hresp", {31'd0, z_hresp}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ahblite_bus_mux.md
# ahblite_bus_mux

Parametrised AHB-Lite address decoder and response multiplexer with a built-in default slave and a stall watchdog. It connects one AHB-Lite master to NS slaves, each slave mapped to one page of the top PW address bits. Transfers to unmapped pages get a protocol-correct two-cycle ERROR response. A slave that stalls the bus past a programmable limit is aborted with an ERROR.

## Interface
- NS, 5: number of slaves (1..16).
- PW, 8: page width; page = HADDR[31:32-PW].
- PAGES, {8'h40,8'h77,8'h48,8'h20,8'h00}: NS*PW packed page map. Slot i is PAGES[i*PW +: PW].
- TO_CYC, 255: watchdog limit in stall cycles (1..65535). 0 disables the watchdog.
- DEF_RDATA, 32'hDEADBEEF: HRDATA driven when no slave owns the data phase.
- Derived localparam IW = max(1, clog2(NS)).
- HCLK  in  1  bus clock; all state on rising edge.
- HRESETn  in  1  reset, asynchronous, active-low.
- HADDR  in  32  master address-phase address.
- HTRANS  in  2  master transfer type; bit 1 = NONSEQ/SEQ (active).
- HREADY  out  1  bus ready to master and all slaves.
- HRESP  out  1  bus response (1 = ERROR).
- HRDATA  out  32  read data to master.
- HSEL  out  NS  one-hot slave selects.
- HREADYOUT_S  in  NS  per-slave ready.
- HRESP_S  in  NS  per-slave response.
- HRDATA_S  in  NS*32  per-slave read data; slot i is [i*32 +: 32].
- TIMEOUT  out  1  one-cycle pulse when the watchdog fires.
- TO_IDX  out  IW  index of the last slave aborted by the watchdog.

## Operation
- **Decode (combinational):**
  - HSEL[i] = (page == PAGES slot i), independent of HTRANS.
  - If two slots hold the same page, the lowest index wins, so HSEL stays one-hot.
  - nomatch = no slot hit.
- **Data-phase select register `asel[NS-1:0]`:**
  - On each cycle with HREADY=1: asel <= HSEL & {NS{HTRANS[1]}}.
  - Held while HREADY=0.
  - Cleared on watchdog abort.
- **Response mux:**
  - If asel[i]=1 and state is IDLE: HREADY=HREADYOUT_S[i], HRESP=HRESP_S[i], HRDATA=HRDATA_S slot i.
  - Otherwise HREADY and HRESP come from the FSM, and HRDATA=DEF_RDATA.
- **FSM states:**
  - IDLE: HREADY/HRESP from mux.
  - ERR1: HREADY=0, HRESP=1.
  - ERR2: HREADY=1, HRESP=1.
  - TO1: HREADY=0, HRESP=1.
  - TO2: HREADY=1, HRESP=1.
- **FSM transitions:**
  - IDLE -> ERR1 when HREADY=1, HTRANS[1]=1 and nomatch.
  - IDLE -> TO1 when the watchdog expires.
  - ERR1 -> ERR2.
  - TO1 -> TO2.
  - ERR2/TO2 -> ERR1 if an unmapped active transfer is accepted in that same cycle, else -> IDLE.
- **Watchdog counter (16 bits):**
  - Increments in IDLE while some asel[i]=1 and HREADYOUT_S[i]=0.
  - Clears to 0 on any cycle with HREADY=1.
  - Expiry: the counter equals TO_CYC-1 and the slave is still low, with TO_CYC != 0.
  - On expiry, the next state is TO1, TIMEOUT pulses for the TO1 cycle, TO_IDX <= i, and asel clears.
  - The slave's HREADYOUT/HRESP/HRDATA are ignored during TO1/TO2.
- Slave-generated ERROR (HRESP_S) passes through unmodified. It neither resets nor triggers the watchdog differently from any other stall.
- IDLE/BUSY transfers (HTRANS[1]=0) never select a slave in the data phase and never start an ERROR; the bus answers HREADY=1, HRESP=0.

## Timing
- **Reset values:**
  - state=IDLE, asel=0, counter=0, TO_IDX=0, TIMEOUT=0.
  - HREADY=1, HRESP=0, HRDATA=DEF_RDATA.
  - HSEL is combinational from HADDR, also during reset.
- Reset asserted mid-transfer: all of the above take effect immediately (asynchronous). The next transfer starts clean.
- HSEL has zero latency from HADDR. The data-phase mux switches one cycle after an address phase is accepted.
- **Unmapped transfer:**
  - Exactly 2 data-phase cycles: {HREADY,HRESP} = {0,1} then {1,1}.
  - Back-to-back unmapped transfers give repeating ERR1/ERR2 with no IDLE gap.
- **Watchdog:**
  - The master sees exactly TO_CYC stall cycles, then TO1 and TO2.
  - A stall that lasts exactly TO_CYC-1 cycles completes normally with no TIMEOUT.
- Single-cycle slave (HREADYOUT_S=1): zero wait states added.

## Test plan
- **Reset:** hold HRESETn=0 with HADDR=32'h2000_0000 -> HSEL=5'b00010, HREADY=1, HRESP=0, HRDATA=32'hDEADBEEF, TIMEOUT=0, TO_IDX=0.
- **Mapped reads:** NONSEQ to pages 00, 20, 48, 77, 40 back-to-back, with all slaves ready and slave i returning 32'hA000_000i -> HRDATA=32'hA0000000..32'hA0000004 on consecutive data phases, zero wait states.
- **Unmapped:** NONSEQ to 32'h1000_0000, followed by a NONSEQ to 32'h0000_0004 -> data phase {HREADY,HRESP}={0,1},{1,1}, HRDATA=DEADBEEF. The following transfer goes to slave 0 with HRESP=0. Repeat with two consecutive unmapped transfers -> ERR1, ERR2, ERR1, ERR2.
- **Slave error passthrough and IDLE transfers:**
  - Slave 2 drives HRESP_S=1 over a 2-cycle error -> the bus mirrors it exactly, with no TIMEOUT.
  - HTRANS=IDLE to an unmapped page -> HRESP stays 0.
- **Watchdog:**
  - TO_CYC=4; slave 3 holds HREADYOUT_S=0 -> 4 stall cycles, then {0,1},{1,1}, TIMEOUT high for exactly 1 cycle, TO_IDX=3, followed by normal IDLE.
  - With a 3-cycle stall -> normal completion, TIMEOUT=0.
  - With TO_CYC=0 and a 1000-cycle stall -> no abort.
- **Async reset mid-stall:** pulse HRESETn low during ERR1 and during a watchdog count of 2 -> immediate HREADY=1, HRESP=0. After release, an unmapped transfer again gets a full 2-cycle ERROR.
